// File: rtl/ack_pipe_if.sv
// Request/acknowledge bundle between a slave's request decode (master side)
// and the ack_pipe latency queue (slave side).
interface ack_pipe_if #(
    parameter int unsigned IDW = 4
);
    logic           req_i;
    logic           we_i;
    logic [IDW-1:0] id_i;
    logic           req_ready_o;
    logic           ack_o;
    logic           ack_we_o;
    logic [IDW-1:0] ack_id_o;

    modport master (
        output req_i, we_i, id_i,
        input  req_ready_o, ack_o, ack_we_o, ack_id_o
    );

    modport slave (
        input  req_i, we_i, id_i,
        output req_ready_o, ack_o, ack_we_o, ack_id_o
    );
endinterface

// File: rtl/ack_pipe.sv
// Multi-outstanding fixed-latency acknowledge generator: in-order circular
// queue of {we, id, countdown}; the head acks once its countdown reaches zero.
module ack_pipe #(
    parameter int unsigned READ_STAGES  = 3,
    parameter int unsigned WRITE_STAGES = 1,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned IDW          = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ce_i,
    input  logic                         flush_i,
    ack_pipe_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         ovf_o
);

    localparam int unsigned RLAT   = (READ_STAGES  == 0) ? 1 : READ_STAGES;
    localparam int unsigned WLAT   = (WRITE_STAGES == 0) ? 1 : WRITE_STAGES;
    localparam int unsigned MAXLAT = (RLAT > WLAT) ? RLAT : WLAT;
    localparam int unsigned CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    localparam logic [CNTW-1:0] RD_LOAD = CNTW'(RLAT - 1);
    localparam logic [CNTW-1:0] WR_LOAD = CNTW'(WLAT - 1);

    logic            we_q  [DEPTH];
    logic            we_d  [DEPTH];
    logic [IDW-1:0]  id_q  [DEPTH];
    logic [IDW-1:0]  id_d  [DEPTH];
    logic [CNTW-1:0] cnt_q [DEPTH];
    logic [CNTW-1:0] cnt_d [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ack_q, ack_d;
    logic            ack_we_q, ack_we_d;
    logic [IDW-1:0]  ack_id_q, ack_id_d;
    logic            ovf_q, ovf_d;

    logic            full;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full            = (count_q == CW'(DEPTH));
    assign bus.req_ready_o = ce_i & ~flush_i & ~full;
    assign push            = bus.req_i & bus.req_ready_o;
    assign pop             = ce_i & ~flush_i & (count_q != '0) & (cnt_q[rd_ptr_q] == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ack_d    = ack_q;
        ack_we_d = ack_we_q;
        ack_id_d = ack_id_q;
        ovf_d    = ovf_q;
        // Stale slots also count down; harmless since a push reloads them.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            we_d[i]  = we_q[i];
            id_d[i]  = id_q[i];
            cnt_d[i] = (ce_i && cnt_q[i] != '0) ? cnt_q[i] - CNTW'(1) : cnt_q[i];
        end

        if (ce_i && flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ack_d    = 1'b0;
            ovf_d    = 1'b0;
        end else if (ce_i) begin
            ack_d = pop;
            if (pop) begin
                ack_we_d = we_q[rd_ptr_q];
                ack_id_d = id_q[rd_ptr_q];
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push) begin
                we_d[wr_ptr_q]  = bus.we_i;
                id_d[wr_ptr_q]  = bus.id_i;
                cnt_d[wr_ptr_q] = bus.we_i ? WR_LOAD : RD_LOAD;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (bus.req_i && full) begin
                ovf_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                we_q[i]  <= 1'b0;
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            ack_we_q <= 1'b0;
            ack_id_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                we_q[i]  <= we_d[i];
                id_q[i]  <= id_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            ack_we_q <= ack_we_d;
            ack_id_q <= ack_id_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ack_o    = ack_q;
    assign bus.ack_we_o = ack_we_q;
    assign bus.ack_id_o = ack_id_q;
    assign count_o      = count_q;
    assign ovf_o        = ovf_q;

endmodule
